// File: rtl/keypad_entry_pkg.sv
// Shared types and constants for the keypad entry block: debounce states,
// the scan-result encoding and the {row,col} to hex key map.
package keypad_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } kp_state_e;

    typedef enum logic {
        SCAN_NONE,
        SCAN_HIT
    } scan_kind_e;

    typedef struct packed {
        scan_kind_e kind;
        logic [3:0] code;
    } scan_result_t;

    // Index is {row[1:0], col[1:0]}; entry 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // A scan is a hit only when exactly one of the 16 positions is pressed.
    function automatic scan_result_t decode_scan(input logic [15:0] pressed);
        scan_result_t res;
        logic [4:0]   hits;
        logic [3:0]   idx;
        hits = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (pressed[i]) begin
                hits = hits + 5'd1;
                idx  = 4'(i);
            end
        end
        res.kind = (hits == 5'd1) ? SCAN_HIT : SCAN_NONE;
        res.code = KEY_MAP[idx];
        return res;
    endfunction

endpackage

// File: rtl/keypad_entry_tick.sv
// Free-running divider that pulses tick once every SCAN_DIV clock cycles;
// each pulse ends the settling window of one keypad column.
module keypad_scan_tick #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_entry.sv
// Scans a 4x4 active-low keypad one column at a time, debounces whole-scan
// results and shifts each accepted hex digit into a 32-bit entry register.
module keypad_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] data
);

    import keypad_entry_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic         tick;
    logic [3:0]   row_meta_q, row_sync_q;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [15:0]  pressed_q, pressed_d;
    logic         scan_evt;
    scan_result_t scan_res;
    kp_state_e    state_q, state_d;
    logic [3:0]   cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic         accept;
    logic         key_valid_q;
    logic [3:0]   key_code_q;
    logic [31:0]  data_q;

    keypad_scan_tick #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_ni(rstn),
        .tick_o(tick)
    );

    // The current column is captured into pressed_d on tick, so the column-3
    // tick sees a complete 16-position snapshot in pressed_d.
    always_comb begin
        col_idx_d = col_idx_q;
        pressed_d = pressed_q;
        if (tick) begin
            col_idx_d = col_idx_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                pressed_d[{2'(r), col_idx_q}] = ~row_sync_q[r];
            end
        end
        scan_evt = tick && (col_idx_q == 2'd3);
        scan_res = decode_scan(pressed_d);
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (scan_evt) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_res.kind == SCAN_HIT) begin
                        cand_d = scan_res.code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (scan_res.kind == SCAN_HIT && scan_res.code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (scan_res.kind == SCAN_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end
    end

    // clr wins over an accept for the entry register only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            col_idx_q   <= 2'd0;
            pressed_q   <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            data_q      <= '0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            col_idx_q   <= col_idx_d;
            pressed_q   <= pressed_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= cand_d;
            end
            if (clr) begin
                data_q <= '0;
            end else if (accept) begin
                data_q <= {data_q[27:0], cand_d};
            end
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign data      = data_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: table-driven digit entry, directed
// bounce/glitch/clr/reset sequences and randomized scans against a scan-level model.
module tb_keypad_entry;

    localparam int SD  = 4;
    localparam int DEB = 3;
    localparam int EDGES_PER_SCAN = SD * 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  row;
    logic        clr;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] data;

    logic [15:0] keys;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;
    int dutPulses   = 0;

    bit          mHeld;
    int          mRun;
    logic [3:0]  mCand;
    logic [3:0]  mCode;
    logic [31:0] mData;

    logic [3:0] tbKeyMap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    typedef struct {
        logic [15:0] keys;
        int          pressScans;
        int          expPulses;
        logic [3:0]  expCode;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs [11];

    keypad_entry #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .row      (row),
        .clr      (clr),
        .col      (col),
        .key_valid(key_valid),
        .key_code (key_code),
        .data     (data)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] expCol(input int c);
        logic [3:0] one;
        int idx;
        one = 4'b0001;
        idx = (c / SD) % 4;
        return ~(one << idx);
    endfunction

    // Scan-level debounce model: one call per full scan of stable keys.
    task automatic modelScan(input logic [15:0] k, output logic acc, output logic [3:0] code);
        int n;
        int idx;
        logic [3:0] kc;
        n   = $countones(k);
        idx = 0;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        kc   = tbKeyMap[idx/4][idx%4];
        acc  = 1'b0;
        code = mCand;
        if (!mHeld) begin
            if (n != 1) mRun = 0;
            else if (mRun == 0) begin
                mCand = kc;
                mRun  = 1;
            end else if (kc == mCand) mRun++;
            else mRun = 0;
            if (mRun == DEB) begin
                acc   = 1'b1;
                code  = mCand;
                mHeld = 1'b1;
                mRun  = 0;
            end
        end else begin
            if (n == 1) mRun = 0;
            else mRun++;
            if (mRun == DEB) begin
                mHeld = 1'b0;
                mRun  = 0;
            end
        end
    endtask

    task automatic resetModel();
        mHeld = 1'b0;
        mRun  = 0;
        mCand = 4'h0;
        mCode = 4'h0;
        mData = 32'h0;
        cyc   = 0;
    endtask

    // One full scan with keys held stable; clrEdge selects which edge sees clr (0 = none).
    task automatic applyStimulus(input logic [15:0] k, input int clrEdge);
        logic acc;
        logic [3:0] accCode;
        keys = k;
        modelScan(k, acc, accCode);
        for (int e = 1; e <= EDGES_PER_SCAN; e++) begin
            clr = (e == clrEdge);
            @(posedge clk);
            #1;
            cyc++;
            if (key_valid === 1'b1) dutPulses++;
            if (clr) mData = 32'h0;
            else if (e == EDGES_PER_SCAN && acc) mData = (mData << 4) | 32'(accCode);
            if (e == EDGES_PER_SCAN && acc) mCode = accCode;
            checkOutput("col", 32'(col), 32'(expCol(cyc)));
            checkOutput("key_valid", 32'(key_valid), 32'(e == EDGES_PER_SCAN && acc));
            checkOutput("key_code", 32'(key_code), 32'(mCode));
            checkOutput("data", data, mData);
        end
        clr = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_col"}, 32'(col), 32'h0000000E);
        checkOutput({tag, "_key_valid"}, 32'(key_valid), 32'h0);
        checkOutput({tag, "_key_code"}, 32'(key_code), 32'h0);
        checkOutput({tag, "_data"}, data, 32'h0);
    endtask

    initial begin
        int p0;
        logic [15:0] bounceSeq [7];
        logic [15:0] glitchSeq [9];

        vecs[0]  = '{16'h0020, 6, 1, 4'h5, 32'h00000005};
        vecs[1]  = '{16'h0001, 3, 1, 4'h1, 32'h00000051};
        vecs[2]  = '{16'h0002, 3, 1, 4'h2, 32'h00000512};
        vecs[3]  = '{16'h0008, 3, 1, 4'hA, 32'h0000512A};
        vecs[4]  = '{16'h2000, 3, 1, 4'hF, 32'h000512AF};
        vecs[5]  = '{16'h1000, 3, 1, 4'h0, 32'h00512AF0};
        vecs[6]  = '{16'h1000, 3, 1, 4'h0, 32'h0512AF00};
        vecs[7]  = '{16'h1000, 3, 1, 4'h0, 32'h512AF000};
        vecs[8]  = '{16'h1000, 3, 1, 4'h0, 32'h12AF0000};
        vecs[9]  = '{16'h0100, 3, 1, 4'h7, 32'h2AF00007};
        vecs[10] = '{16'h0084, 5, 0, 4'h7, 32'h2AF00007};

        bounceSeq = '{16'h0400, 16'h0400, 16'h0000, 16'h0400, 16'h0400, 16'h0000, 16'h0000};
        glitchSeq = '{16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'h0010,
                      16'h0000, 16'h0000, 16'h0000};

        rstn = 1'b1;
        clr  = 1'b0;
        keys = 16'h0;
        #2 rstn = 1'b0;
        #1 checkReset("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        resetModel();

        repeat (2) applyStimulus(16'h0, 0);

        for (int v = 0; v < 11; v++) begin
            p0 = dutPulses;
            repeat (vecs[v].pressScans) applyStimulus(vecs[v].keys, 0);
            repeat (3) applyStimulus(16'h0, 0);
            checkOutput($sformatf("vec%0d_pulses", v), 32'(dutPulses - p0), 32'(vecs[v].expPulses));
            checkOutput($sformatf("vec%0d_code", v), 32'(key_code), 32'(vecs[v].expCode));
            checkOutput($sformatf("vec%0d_data", v), data, vecs[v].expData);
        end

        p0 = dutPulses;
        for (int i = 0; i < 7; i++) applyStimulus(bounceSeq[i], 0);
        checkOutput("bounce_pulses", 32'(dutPulses - p0), 32'h0);
        checkOutput("bounce_data", data, 32'h2AF00007);

        p0 = dutPulses;
        for (int i = 0; i < 9; i++) applyStimulus(glitchSeq[i], 0);
        checkOutput("glitch_pulses", 32'(dutPulses - p0), 32'h1);
        checkOutput("glitch_code", 32'(key_code), 32'h4);
        checkOutput("glitch_data", data, 32'hAF000074);

        applyStimulus(16'h0100, 0);
        repeat (6) @(posedge clk);
        #3 rstn = 1'b0;
        #1 checkReset("midreset");
        keys = 16'h0;
        @(negedge clk) rstn = 1'b1;
        resetModel();

        repeat (3) applyStimulus(16'h0001, 0);
        repeat (3) applyStimulus(16'h0000, 0);
        repeat (3) applyStimulus(16'h0002, 0);
        repeat (3) applyStimulus(16'h0000, 0);
        checkOutput("preclr_data", data, 32'h00000012);
        repeat (2) applyStimulus(16'h4000, 0);
        applyStimulus(16'h4000, EDGES_PER_SCAN);
        checkOutput("clr_key_valid", 32'(key_valid), 32'h1);
        checkOutput("clr_key_code", 32'(key_code), 32'hE);
        checkOutput("clr_data", data, 32'h0);
        repeat (3) applyStimulus(16'h0000, 0);

        for (int seg = 0; seg < 25; seg++) begin
            int sel;
            int len;
            int a;
            int b;
            logic [15:0] k;
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 5);
            a   = $urandom_range(0, 15);
            b   = (a + $urandom_range(1, 15)) % 16;
            if (sel < 4) k = 16'h0;
            else if (sel < 9) k = 16'h1 << a;
            else k = (16'h1 << a) | (16'h1 << b);
            for (int s = 0; s < len; s++) begin
                applyStimulus(k, ($urandom_range(0, 19) == 0) ? $urandom_range(1, EDGES_PER_SCAN) : 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the 7-segment display driver.
- Scans a 4x4 active-low matrix keypad by driving one column at a time, like the display multiplexes its anodes, and reads the row lines back.
- Debounces key presses and shifts each accepted hex digit into a 32-bit entry register.
- The entry register feeds the display's 32-bit data input and downstream datapath logic.

Parameters:
SCAN_DIV, 100000, clk cycles each column is driven (1 kHz column rate at 100 MHz); minimum 2
DEBOUNCE_SCANS, 4, consecutive identical full scans (4 columns each) needed to accept a press or a release; minimum 1

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
row  input  4  keypad row lines, active-low, asynchronous to clk
clr  input  1  synchronous clear of the entry register, active-high
col  output  4  keypad column drive, active-low, exactly one bit low
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  hex code of the last accepted key
data  output  32  entry register, newest digit in bits [3:0]

Behaviour:
- Reset (rstn low, asynchronous):
  - col=4'b1110 (column 0), key_valid=0, key_code=0, data=0.
  - Tick counter=0, FSM=IDLE, synchronizer flops=4'b1111.
- Row synchronizer: 2-flop synchronizer on row; all logic uses the synchronized value.
- Tick generator:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - tick is high for the single cycle where counter==SCAN_DIV-1.
- Column scan:
  - col_idx (0..3) advances on tick and wraps 3->0.
  - col = ~(4'b0001 << col_idx).
  - On tick, the synchronized row for the current column is captured before col_idx advances, so each column settles for SCAN_DIV cycles.
- Scan result:
  - Evaluated on the tick that samples column 3.
  - HIT(k) if exactly one key was low across all 16 positions; otherwise NONE. Multiple simultaneous keys count as NONE.
- Key map (row r, col c -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce FSM (updates only on scan-result events):
  - IDLE:
    - HIT(k): cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately and go to HELD; else go to PRESS_CHK.
    - NONE: stay.
  - PRESS_CHK:
    - HIT(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - HIT of another key, or NONE: go to IDLE.
  - HELD:
    - NONE: cnt=1, go to RELEASE_CHK (immediate IDLE if DEBOUNCE_SCANS==1).
    - Any HIT: stay. No auto-repeat; other keys are ignored while held.
  - RELEASE_CHK:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - Any HIT: go back to HELD. No new accept.
- Accept (all registered on the same clk edge):
  - key_valid=1 for exactly one cycle.
  - key_code=cand; key_code holds until the next accept.
  - data <= {data[27:0], cand}.
- Latency: a key held stable is accepted on the scan-end tick of the DEBOUNCE_SCANS-th full scan that sees it.
- clr:
  - data<=0 next edge; takes priority over a simultaneous accept.
  - key_valid and key_code still behave normally in that cycle.
  - FSM and scan are unaffected.
- Overflow: after 8 digits the oldest digit shifts out of [31:28]; no flag.
- Widths: cnt is sized $clog2(DEBOUNCE_SCANS+1) and saturates at DEBOUNCE_SCANS.

Decomposition:
- Shared package holds:
  - FSM state enum: IDLE, PRESS_CHK, HELD, RELEASE_CHK.
  - 16-entry key map constant, indexed {row,col}.
  - NONE/HIT encoding of the scan result.
- One sub-module: keypad_scan_tick, the parameterized SCAN_DIV counter producing tick. The top block holds the synchronizer, column scan, FSM and entry register.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3 (16 cycles per full scan); the keypad model drives row low when the held key's column is low.
- Reset then idle -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserted; data=0.
- Hold key r1c1 ('5') for 6 scans -> one key_valid pulse at the end of scan 3; key_code=5, data=32'h00000005; no further pulse while held.
- Enter 1,2,A,F with clean press/release each, then 5 more digits -> data=32'h12AF0000 after four more zeros; after the 9th digit '7' -> data=32'h2AF00007 (oldest digit dropped).
- Bounce: key '9' present 2 scans, absent 1, present 2, then released -> no key_valid. Also hold '3' and 'B' together for 5 scans -> no key_valid.
- Release glitch: hold '4' until accepted, release for 2 scans, press again for 1 scan, release for 3 scans -> exactly one key_valid total.
- clr asserted in the same cycle as the accept of 'E' with data=32'h00000012 -> key_valid=1, key_code=E, data=0. Async rstn pulse mid-PRESS_CHK -> outputs return to reset values immediately.
